// File: rtl/mem_game_ctrl.sv
// Memory-game round controller: shows a random sequence value by value,
// then checks the player's recalled guesses against it.
module mem_game_ctrl #(
  parameter int unsigned SEQ_LEN    = 10,
  parameter int unsigned VAL_W      = 5,
  parameter int unsigned SHOW_TICKS = 4,
  parameter int unsigned MAX_GUESS  = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             go,
  input  logic [VAL_W-1:0] rnd_in,
  output logic             rnd_adv,
  input  logic             plus_one,
  input  logic             enter,
  output logic [VAL_W-1:0] guess,
  output logic [VAL_W-1:0] show_val,
  output logic             show_en,
  output logic [7:0]       led,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  localparam int unsigned IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_RECALL  = 3'd2;
  localparam logic [2:0] S_WIN     = 3'd3;
  localparam logic [2:0] S_LOSE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [VAL_W-1:0] guess_q, guess_d;
  logic [VAL_W-1:0] show_val_q, show_val_d;
  logic             show_en_q, show_en_d;
  logic [7:0]       led_q, led_d;
  logic             rnd_adv_q, rnd_adv_d;
  logic             busy_q, busy_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;

  logic [VAL_W-1:0] mem_q [SEQ_LEN];
  logic             mem_we;
  logic [2:0]       led_bit;
  logic             idx_last;

  // Sequence storage; contents are meaningless outside a round, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= rnd_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tick_cnt_q <= '0;
      guess_q    <= '0;
      show_val_q <= '0;
      show_en_q  <= 1'b0;
      led_q      <= 8'h00;
      rnd_adv_q  <= 1'b0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tick_cnt_q <= tick_cnt_d;
      guess_q    <= guess_d;
      show_val_q <= show_val_d;
      show_en_q  <= show_en_d;
      led_q      <= led_d;
      rnd_adv_q  <= rnd_adv_d;
      busy_q     <= busy_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tick_cnt_d = tick_cnt_q;
    guess_d    = guess_q;
    show_val_d = show_val_q;
    show_en_d  = show_en_q;
    led_d      = led_q;
    rnd_adv_d  = 1'b0;
    busy_d     = busy_q;
    win_d      = win_q;
    lose_d     = lose_q;
    mem_we     = 1'b0;
    idx_last   = (idx_q == IW'(SEQ_LEN - 1));
    // Progress thermometer saturates on the top LED for long sequences.
    if (32'(idx_q) >= 32'd7) begin
      led_bit = 3'd7;
    end else begin
      led_bit = 3'(idx_q);
    end

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (go) begin
          state_d    = S_CAPTURE;
          idx_d      = '0;
          tick_cnt_d = '0;
          guess_d    = '0;
          led_d      = 8'h00;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          show_en_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_CAPTURE: begin
        if (tick) begin
          if (tick_cnt_q == '0) begin
            mem_we     = 1'b1;
            show_val_d = rnd_in;
            show_en_d  = 1'b1;
            rnd_adv_d  = 1'b1;
          end
          // Last display tick of this value: move on, or hand over to recall.
          if (tick_cnt_q == TW'(SHOW_TICKS - 1)) begin
            tick_cnt_d = '0;
            if (idx_last) begin
              state_d    = S_RECALL;
              idx_d      = '0;
              show_en_d  = 1'b0;
              show_val_d = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      S_RECALL: begin
        // Enter wins over a simultaneous plus_one, which is dropped.
        if (enter) begin
          guess_d = '0;
          if (guess_q == mem_q[idx_q]) begin
            led_d[led_bit] = 1'b1;
            if (idx_last) begin
              state_d = S_WIN;
              led_d   = 8'hFF;
              win_d   = 1'b1;
              busy_d  = 1'b0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            state_d = S_LOSE;
            led_d   = 8'h00;
            lose_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (plus_one) begin
          if (guess_q == VAL_W'(MAX_GUESS)) begin
            guess_d = '0;
          end else begin
            guess_d = guess_q + VAL_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rnd_adv  = rnd_adv_q;
  assign guess    = guess_q;
  assign show_val = show_val_q;
  assign show_en  = show_en_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_mem_game_ctrl.sv
// Bench for mem_game_ctrl: a round-level model checked every cycle, plus
// directed rounds with literal expectations (capture, win, lose, wrap, reset).
module tb_mem_game_ctrl;

  localparam int SEQ_LEN    = 3;
  localparam int VAL_W      = 5;
  localparam int SHOW_TICKS = 2;
  localparam int MAX_GUESS  = 31;

  localparam int P_IDLE = 0;
  localparam int P_CAP  = 1;
  localparam int P_REC  = 2;
  localparam int P_WIN  = 3;
  localparam int P_LOSE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tick = 1'b0;
  logic             go = 1'b0;
  logic             plus_one = 1'b0;
  logic             enter = 1'b0;
  logic [VAL_W-1:0] rnd_in = '0;
  logic             rnd_adv;
  logic [VAL_W-1:0] guess;
  logic [VAL_W-1:0] show_val;
  logic             show_en;
  logic [7:0]       led;
  logic             busy;
  logic             win;
  logic             lose;

  mem_game_ctrl #(
    .SEQ_LEN   (SEQ_LEN),
    .VAL_W     (VAL_W),
    .SHOW_TICKS(SHOW_TICKS),
    .MAX_GUESS (MAX_GUESS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .go      (go),
    .rnd_in  (rnd_in),
    .rnd_adv (rnd_adv),
    .plus_one(plus_one),
    .enter   (enter),
    .guess   (guess),
    .show_val(show_val),
    .show_en (show_en),
    .led     (led),
    .busy    (busy),
    .win     (win),
    .lose    (lose)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit cmp_en = 1'b0;
  int adv_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Round-level model: phase, ticks seen, captured values, correct count.
  int m_phase   = P_IDLE;
  int m_ticks   = 0;
  int m_correct = 0;
  int m_guess   = 0;
  bit m_adv     = 1'b0;
  int m_seq[$];

  function automatic logic [7:0] therm(input int n);
    return (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = P_IDLE; m_ticks = 0; m_correct = 0; m_guess = 0; m_adv = 1'b0;
        m_seq.delete();
      end else begin
        m_adv = 1'b0;
        case (m_phase)
          P_CAP: if (tick) begin
            if (m_ticks % SHOW_TICKS == 0) begin
              m_seq.push_back(int'(rnd_in));
              m_adv = 1'b1;
            end
            m_ticks++;
            if (m_ticks == SEQ_LEN * SHOW_TICKS) m_phase = P_REC;
          end
          P_REC: begin
            if (enter) begin
              if (m_guess == m_seq[m_correct]) begin
                m_correct++;
                if (m_correct == SEQ_LEN) m_phase = P_WIN;
              end else begin
                m_phase = P_LOSE;
              end
              m_guess = 0;
            end else if (plus_one) begin
              m_guess = (m_guess + 1) % (MAX_GUESS + 1);
            end
          end
          default: if (go) begin
            m_phase = P_CAP; m_ticks = 0; m_correct = 0; m_guess = 0;
            m_seq.delete();
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [7:0] e_led;
  bit         e_en;
  int         e_show;
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_adv === 1'b1) adv_cnt++;
      if (cmp_en) begin
        e_led  = (m_phase == P_WIN) ? 8'hFF : (m_phase == P_LOSE) ? 8'h00 : therm(m_correct);
        e_en   = (m_phase == P_CAP) && (m_seq.size() > 0);
        e_show = e_en ? m_seq[$] : 0;
        check("m_busy", 32'(busy), 32'((m_phase == P_CAP) || (m_phase == P_REC)));
        check("m_win", 32'(win), 32'(m_phase == P_WIN));
        check("m_lose", 32'(lose), 32'(m_phase == P_LOSE));
        check("m_led", 32'(led), 32'(e_led));
        check("m_show_en", 32'(show_en), 32'(e_en));
        check("m_show_val", 32'(show_val), 32'(e_show));
        check("m_guess", 32'(guess), 32'(m_guess));
        check("m_rnd_adv", 32'(rnd_adv), 32'(m_adv));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic pulse_go();
    go = 1'b1; @(negedge clk); go = 1'b0;
  endtask

  task automatic pulse_plus(input int n);
    for (int i = 0; i < n; i++) begin
      plus_one = 1'b1; @(negedge clk); plus_one = 1'b0;
    end
  endtask

  task automatic pulse_enter();
    enter = 1'b1; @(negedge clk); enter = 1'b0;
  endtask

  task automatic enter_guess(input int v);
    pulse_plus(v);
    pulse_enter();
  endtask

  // Show three values; a go+enter is injected on every hold cycle.
  task automatic run_capture(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    logic [4:0] v [3];
    v = '{a, b, c};
    adv_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      rnd_in = v[k]; tick = 1'b1; @(negedge clk); tick = 1'b0;
      check("cap_show_val", 32'(show_val), 32'(v[k]));
      check("cap_rnd_adv_hi", 32'(rnd_adv), 32'd1);
      go = 1'b1; enter = 1'b1; @(negedge clk); go = 1'b0; enter = 1'b0;
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      check("cap_rnd_adv_lo", 32'(rnd_adv), 32'd0);
    end
    check("cap_adv_count", 32'(adv_cnt), 32'd3);
    check("recall_show_en", 32'(show_en), 32'd0);
    check("recall_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_show_en", 32'(show_en), 32'd0);
    check("rst_guess", 32'(guess), 32'd0);
    cmp_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    tick = 1'b1; enter = 1'b1; plus_one = 1'b1; @(negedge clk);
    tick = 1'b0; enter = 1'b0; plus_one = 1'b0;
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_guess", 32'(guess), 32'd0);

    // Round 1: win
    pulse_go();
    check("go_busy", 32'(busy), 32'd1);
    run_capture(5'd7, 5'd19, 5'd2);
    enter_guess(7);
    check("win_led1", 32'(led), 32'h01);
    check("win_guess_clr", 32'(guess), 32'd0);
    enter_guess(19);
    check("win_led2", 32'(led), 32'h03);
    enter_guess(2);
    check("win_led3", 32'(led), 32'hFF);
    check("win_flag", 32'(win), 32'd1);
    check("win_busy", 32'(busy), 32'd0);

    // Round 2: restart from WIN, then lose
    pulse_go();
    check("restart_led", 32'(led), 32'h00);
    check("restart_win", 32'(win), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    run_capture(5'd7, 5'd19, 5'd2);
    enter_guess(7);
    check("lose_led1", 32'(led), 32'h01);
    enter_guess(18);
    check("lose_led", 32'(led), 32'h00);
    check("lose_flag", 32'(lose), 32'd1);
    check("lose_busy", 32'(busy), 32'd0);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("lose_tick_ignored", 32'(lose), 32'd1);

    // Round 3: wrap, simultaneous plus_one/enter, go ignored in recall
    pulse_go();
    run_capture(5'd6, 5'd30, 5'd1);
    pulse_go();
    check("recall_go_ignored", 32'(busy), 32'd1);
    pulse_plus(33);
    check("wrap_guess", 32'(guess), 32'd1);
    pulse_plus(5);
    check("pre_simul_guess", 32'(guess), 32'd6);
    plus_one = 1'b1; enter = 1'b1; @(negedge clk); plus_one = 1'b0; enter = 1'b0;
    check("simul_led", 32'(led), 32'h01);
    check("simul_guess", 32'(guess), 32'd0);
    pulse_plus(4);
    check("pre_rst_guess", 32'(guess), 32'd4);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_led", 32'(led), 32'd0);
    check("arst_guess", 32'(guess), 32'd0);
    check("arst_show_en", 32'(show_en), 32'd0);
    check("arst_show_val", 32'(show_val), 32'd0);
    check("arst_rnd_adv", 32'(rnd_adv), 32'd0);
    check("arst_win_lose", 32'({win, lose}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_plus(2);
    pulse_enter();
    check("post_rst_idle_guess", 32'(guess), 32'd0);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    pulse_go();
    check("post_rst_go_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_game_ctrl.md
MEM_GAME_CTRL -- requirements
Module: mem_game_ctrl

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 10: number of values per round, range 2..16.
REQ-002 SHALL have parameter VAL_W, default 5: width of random, display and guess values.
REQ-003 SHALL have parameter SHOW_TICKS, default 4: ticks each value is displayed, at least 1.
REQ-004 SHALL have parameter MAX_GUESS, default 31: guess wraps from this value to 0.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port tick, input, 1: one-cycle pulse from the slow-rate divider.
REQ-008 SHALL have port go, input, 1: one-cycle start-round pulse, already synchronized.
REQ-009 SHALL have port rnd_in, input, VAL_W: current LFSR value.
REQ-010 SHALL have port rnd_adv, output, 1: one-cycle pulse telling the LFSR to step.
REQ-011 SHALL have port plus_one, input, 1: one-cycle guess-increment pulse.
REQ-012 SHALL have port enter, input, 1: one-cycle guess-submit pulse.
REQ-013 SHALL have port guess, output, VAL_W: current guess value.
REQ-014 SHALL have port show_val, output, VAL_W: value for the 7-segment path.
REQ-015 SHALL have port show_en, output, 1: display blank when 0.
REQ-016 SHALL have port led, output, 8: progress LEDs.
REQ-017 SHALL have ports busy, win and lose, each output, 1: status flags.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, RECALL, WIN and LOSE; all outputs registered.
REQ-019 IDLE, WIN or LOSE plus go SHALL enter CAPTURE next cycle, with these updates:
  - idx=0, tick_cnt=0, guess=0, led=0
  - win=0, lose=0, show_en=0, busy=1
REQ-020 CAPTURE SHALL respond to tick as follows; non-tick cycles hold all state:
  - tick with tick_cnt=0: store rnd_in into mem[idx], load show_val=rnd_in, set show_en=1
  - rnd_adv SHALL pulse for exactly that one cycle
REQ-021 CAPTURE tick_cnt SHALL count 0..SHOW_TICKS-1; tick at SHOW_TICKS-1 SHALL reset tick_cnt=0 and increment idx.
REQ-022 If idx=SEQ_LEN-1 on that last tick, the controller SHALL go to RECALL, set idx=0, show_en=0 and show_val=0.
REQ-023 RECALL plus_one SHALL increment guess, wrapping MAX_GUESS to 0; plus_one outside RECALL is ignored.
REQ-024 RECALL enter SHALL compare guess with mem[idx], then clear guess to 0.
REQ-025 On a match in RECALL:
  - led SHALL set bit min(idx,7), giving a thermometer that saturates at 8'hFF
  - idx SHALL increment
  - a match at idx=SEQ_LEN-1 SHALL go to WIN
REQ-026 A mismatch in RECALL SHALL go to LOSE next cycle.
REQ-027 WIN SHALL show led=8'hFF, win=1, busy=0. LOSE SHALL show led=8'h00, lose=1, busy=0.
REQ-028 plus_one and enter in the same cycle: compare uses the pre-increment guess; increment is discarded.
REQ-029 go during CAPTURE or RECALL SHALL be ignored; tick outside CAPTURE SHALL be ignored.
REQ-030 enter outside RECALL SHALL be ignored.
REQ-031 Latency: go at edge k gives busy=1 at k+1. enter at edge k gives the led/state update at k+1.
REQ-032 Comparison SHALL be exact VAL_W-bit equality; mem SHALL hold SEQ_LEN entries of VAL_W bits.

Reset
REQ-033 rst low SHALL immediately force the following, regardless of clk:
  - state IDLE, idx=0, tick_cnt=0, guess=0
  - show_val=0, show_en=0, led=0, rnd_adv=0, busy=0, win=0, lose=0
REQ-034 Reset mid-round SHALL abandon the round; mem contents are don't-care after reset.
REQ-035 Release of rst SHALL take effect synchronously; the first active edge after release evaluates from IDLE.

Verification (SEQ_LEN=3, SHOW_TICKS=2, VAL_W=5, MAX_GUESS=31)
REQ-036 Capture: with rnd_in 7, 19, 2 at successive captures:
  - go -> rnd_adv pulses 3 times, each 2 ticks apart
  - show_val sequence is 7, 19, 2
  - then RECALL with show_en=0
REQ-037 Win: enter guesses 7, 19, 2 -> led=01, 03, then FF with win=1 and busy=0.
REQ-038 Lose: enter 7, then enter 18 -> led=01, then LOSE with led=00 and lose=1.
REQ-039 Wrap and simultaneity, both in RECALL:
  - 33 plus_one pulses -> guess=1
  - plus_one with enter at guess=6 -> compare uses 6, guess=0 after
REQ-040 Ignore and restart: while in CAPTURE, go and enter -> no effect; go from WIN -> new CAPTURE with led=00 and win=0.
REQ-041 Reset mid-RECALL: rst low -> all outputs at reset values within the same cycle, state IDLE.
